// File: rtl/insn_fetch_queue_if.sv
// ---------------------------------------------------------------------------
// insn_fetch_queue_if
// Bundles the instruction-queue connections: the redirect input from execute,
// the instruction-memory read port, the decode valid/ready port and the
// occupancy status.
//   redirect_i / redirect_pc_i : flush and restart fetch at the target
//   imem_req_o / imem_addr_o   : read request and address (1-cycle latency)
//   imem_data_i                : read data for the previous cycle's request
//   d_valid_o / d_ready_i      : decode handshake on the head entry
//   d_pc_o / d_insn_o          : head entry contents
//   count_o / empty_o / full_o : queue occupancy
// Modport slave is the queue itself; master is the surrounding core or bench.
// ---------------------------------------------------------------------------
interface insn_fetch_queue_if #(
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic              redirect_i;
    logic [AWIDTH-1:0] redirect_pc_i;
    logic              imem_req_o;
    logic [AWIDTH-1:0] imem_addr_o;
    logic [DWIDTH-1:0] imem_data_i;
    logic              d_valid_o;
    logic              d_ready_i;
    logic [AWIDTH-1:0] d_pc_o;
    logic [DWIDTH-1:0] d_insn_o;
    logic [CW-1:0]     count_o;
    logic              empty_o;
    logic              full_o;

    modport slave (
        input  redirect_i, redirect_pc_i, imem_data_i, d_ready_i,
        output imem_req_o, imem_addr_o, d_valid_o, d_pc_o, d_insn_o,
               count_o, empty_o, full_o
    );

    modport master (
        output redirect_i, redirect_pc_i, imem_data_i, d_ready_i,
        input  imem_req_o, imem_addr_o, d_valid_o, d_pc_o, d_insn_o,
               count_o, empty_o, full_o
    );
endinterface

// File: rtl/insn_fetch_queue.sv
// ---------------------------------------------------------------------------
// insn_fetch_queue
// Prefetch queue between the instruction memory and decode. Generates
// sequential fetch PCs, issues reads with 1-cycle latency and buffers
// {pc, insn} pairs in a circular FIFO drained by decode. A redirect flushes
// the FIFO, drops any in-flight read and restarts fetch at the target.
//   clk : clock, rising edge
//   rst : synchronous active-high reset (priority over redirect)
//   bus : insn_fetch_queue_if.slave (redirect, imem port, decode port, status)
// ---------------------------------------------------------------------------
module insn_fetch_queue #(
    parameter int unsigned       AWIDTH   = 32,
    parameter int unsigned       DWIDTH   = 32,
    parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(32'h01000000),
    parameter int unsigned       DEPTH    = 4
) (
    input logic              clk,
    input logic              rst,
    insn_fetch_queue_if.slave bus
);
    localparam int unsigned       PW      = $clog2(DEPTH);
    localparam int unsigned       CW      = PW + 1;
    localparam logic [CW:0]       LP_CRED = (CW+1)'(DEPTH);
    localparam logic [CW-1:0]     LP_FULL = CW'(DEPTH);
    localparam logic [DWIDTH-1:0] LP_NOP  = DWIDTH'(32'h00000013);

    logic [AWIDTH-1:0] r_fetch_pc;
    logic              r_req_q;
    logic [AWIDTH-1:0] r_req_pc;
    logic [AWIDTH-1:0] r_pc_mem   [DEPTH];
    logic [DWIDTH-1:0] r_insn_mem [DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;

    logic w_issue;
    logic w_push;
    logic w_valid;
    logic w_pop;
    logic w_unused_pc_lsbs;

    // Credit counts the in-flight read as occupied; a same-cycle pop is not
    // credited so the request never depends combinationally on d_ready_i.
    always_comb begin
        w_issue = !rst && !bus.redirect_i &&
                  (({1'b0, r_count} + {{CW{1'b0}}, r_req_q}) < LP_CRED);
        w_push  = r_req_q && !bus.redirect_i;
        w_valid = !rst && (r_count != '0) && !bus.redirect_i;
        w_pop   = w_valid && bus.d_ready_i;
        w_unused_pc_lsbs = ^bus.redirect_pc_i[1:0];
    end

    always_comb begin
        bus.imem_req_o  = w_issue;
        bus.imem_addr_o = r_fetch_pc;
        bus.d_valid_o   = w_valid;
        bus.d_pc_o      = '0;
        bus.d_insn_o    = LP_NOP;
        bus.count_o     = '0;
        if (!rst) begin
            bus.count_o = r_count;
            if (r_count != '0) begin
                bus.d_pc_o   = r_pc_mem[r_head];
                bus.d_insn_o = r_insn_mem[r_head];
            end
        end
        bus.empty_o = (bus.count_o == '0);
        bus.full_o  = (bus.count_o == LP_FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= BASEADDR;
            r_req_q    <= 1'b0;
            r_req_pc   <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_pc_mem   <= '{default: '0};
            r_insn_mem <= '{default: '0};
        end else if (bus.redirect_i) begin
            r_fetch_pc <= {bus.redirect_pc_i[AWIDTH-1:2], 2'b00};
            r_req_q    <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            r_req_q <= w_issue;
            if (w_issue) begin
                r_req_pc   <= r_fetch_pc;
                r_fetch_pc <= r_fetch_pc + AWIDTH'(4);
            end
            if (w_push) begin
                r_pc_mem[r_tail]   <= r_req_pc;
                r_insn_mem[r_tail] <= bus.imem_data_i;
                r_tail             <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_insn_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_insn_fetch_queue
// Directed bench for insn_fetch_queue (DEPTH=4) with a 1-cycle-latency
// instruction memory model.
// ---------------------------------------------------------------------------
module tb_insn_fetch_queue;
    localparam logic [31:0] BASE = 32'h01000000;
    localparam logic [31:0] NOP  = 32'h00000013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    bit   mem_mode = 1'b0;

    always #5 clk = ~clk;

    insn_fetch_queue_if #(.AWIDTH(32), .DWIDTH(32), .DEPTH(4)) bus ();

    insn_fetch_queue #(
        .AWIDTH(32), .DWIDTH(32), .BASEADDR(32'h01000000), .DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return mem_mode ? (a ^ 32'hC0DE0000) : NOP;
    endfunction

    // instruction memory: data for the address requested last cycle
    always @(posedge clk) begin
        if (bus.imem_req_o) bus.imem_data_i <= mem_word(bus.imem_addr_o);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        rst = 1'b1;
        bus.redirect_i = 1'b0;
        bus.redirect_pc_i = '0;
        bus.d_ready_i = rdy;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.redirect_i = 1'b0;
        bus.redirect_pc_i = '0;
        bus.d_ready_i = 1'b1;
        bus.imem_data_i = '0;
        step();
        #1;
        total++; if (bus.d_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus.d_valid_o); end
        total++; if (bus.d_pc_o !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", bus.d_pc_o); end
        total++; if (bus.d_insn_o !== NOP) begin bad++; $display("FAIL rst_insn got=%h exp=%h", bus.d_insn_o, NOP); end
        total++; if (bus.empty_o !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b exp=1", bus.empty_o); end
        total++; if (bus.full_o !== 1'b0) begin bad++; $display("FAIL rst_full got=%b exp=0", bus.full_o); end
        total++; if (bus.count_o !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", bus.count_o); end
        total++; if (bus.imem_req_o !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", bus.imem_req_o); end
        step();
        rst = 1'b0;
        #1;
        total++; if (bus.d_valid_o !== 1'b0) begin bad++; $display("FAIL post_rst_valid got=%b exp=0", bus.d_valid_o); end
        total++; if (bus.imem_req_o !== 1'b1) begin bad++; $display("FAIL post_rst_req got=%b exp=1", bus.imem_req_o); end
        total++; if (bus.imem_addr_o !== BASE) begin bad++; $display("FAIL post_rst_addr got=%h exp=%h", bus.imem_addr_o, BASE); end
    endtask

    task automatic test_stream();
        mem_mode = 1'b0;
        do_reset(1'b1);
        for (int k = 0; k < 10; k++) begin
            #1;
            total++; if (bus.imem_req_o !== 1'b1) begin bad++; $display("FAIL stream_req k=%0d got=%b exp=1", k, bus.imem_req_o); end
            total++; if (bus.imem_addr_o !== BASE + 32'(4*k)) begin bad++; $display("FAIL stream_addr k=%0d got=%h exp=%h", k, bus.imem_addr_o, BASE + 32'(4*k)); end
            total++; if (bus.d_valid_o !== (k >= 2)) begin bad++; $display("FAIL stream_valid k=%0d got=%b exp=%b", k, bus.d_valid_o, k >= 2); end
            if (k >= 2) begin
                total++; if (bus.d_pc_o !== BASE + 32'(4*(k-2))) begin bad++; $display("FAIL stream_pc k=%0d got=%h exp=%h", k, bus.d_pc_o, BASE + 32'(4*(k-2))); end
                total++; if (bus.d_insn_o !== NOP) begin bad++; $display("FAIL stream_insn k=%0d got=%h exp=%h", k, bus.d_insn_o, NOP); end
            end
            step();
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_pc;
        mem_mode = 1'b1;
        do_reset(1'b0);
        for (int k = 0; k < 10; k++) step();
        #1;
        total++; if (bus.full_o !== 1'b1) begin bad++; $display("FAIL stall_full got=%b exp=1", bus.full_o); end
        total++; if (bus.count_o !== 3'd4) begin bad++; $display("FAIL stall_count got=%0d exp=4", bus.count_o); end
        total++; if (bus.imem_req_o !== 1'b0) begin bad++; $display("FAIL stall_req got=%b exp=0", bus.imem_req_o); end
        total++; if (bus.d_pc_o !== BASE) begin bad++; $display("FAIL stall_head got=%h exp=%h", bus.d_pc_o, BASE); end
        bus.d_ready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_pc = BASE + 32'(4*k);
            total++; if (bus.d_valid_o !== 1'b1) begin bad++; $display("FAIL drain_valid k=%0d got=%b exp=1", k, bus.d_valid_o); end
            total++; if (bus.d_pc_o !== exp_pc) begin bad++; $display("FAIL drain_pc k=%0d got=%h exp=%h", k, bus.d_pc_o, exp_pc); end
            total++; if (bus.d_insn_o !== mem_word(exp_pc)) begin bad++; $display("FAIL drain_insn k=%0d got=%h exp=%h", k, bus.d_insn_o, mem_word(exp_pc)); end
            if (k == 0) begin
                total++; if (bus.imem_req_o !== 1'b0) begin bad++; $display("FAIL drain_req0 got=%b exp=0", bus.imem_req_o); end
            end
            if (k == 1) begin
                total++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== BASE + 32'h10) begin bad++; $display("FAIL drain_resume got=%b/%h exp=1/%h", bus.imem_req_o, bus.imem_addr_o, BASE + 32'h10); end
            end
            step();
        end
    endtask

    task automatic test_redirect();
        mem_mode = 1'b1;
        do_reset(1'b0);
        for (int k = 0; k < 4; k++) step();
        #1;
        total++; if (bus.count_o !== 3'd3) begin bad++; $display("FAIL redir_pre_count got=%0d exp=3", bus.count_o); end
        bus.redirect_i = 1'b1;
        bus.redirect_pc_i = 32'h01000100;
        #1;
        total++; if (bus.d_valid_o !== 1'b0) begin bad++; $display("FAIL redir_valid got=%b exp=0", bus.d_valid_o); end
        total++; if (bus.imem_req_o !== 1'b0) begin bad++; $display("FAIL redir_req got=%b exp=0", bus.imem_req_o); end
        step();
        bus.redirect_i = 1'b0;
        bus.d_ready_i = 1'b1;
        #1;
        total++; if (bus.count_o !== 3'd0) begin bad++; $display("FAIL redir_count got=%0d exp=0", bus.count_o); end
        total++; if (bus.d_valid_o !== 1'b0) begin bad++; $display("FAIL redir_next_valid got=%b exp=0", bus.d_valid_o); end
        total++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h01000100) begin bad++; $display("FAIL redir_issue got=%b/%h exp=1/01000100", bus.imem_req_o, bus.imem_addr_o); end
        step();
        #1;
        total++; if (bus.d_valid_o !== 1'b0) begin bad++; $display("FAIL redir_stale got=%b exp=0", bus.d_valid_o); end
        step();
        #1;
        total++; if (bus.d_valid_o !== 1'b1 || bus.d_pc_o !== 32'h01000100) begin bad++; $display("FAIL redir_target got=%b/%h exp=1/01000100", bus.d_valid_o, bus.d_pc_o); end
        total++; if (bus.d_insn_o !== mem_word(32'h01000100)) begin bad++; $display("FAIL redir_insn got=%h exp=%h", bus.d_insn_o, mem_word(32'h01000100)); end
        step();
        #1;
        total++; if (bus.d_pc_o !== 32'h01000104) begin bad++; $display("FAIL redir_next_pc got=%h exp=01000104", bus.d_pc_o); end
    endtask

    task automatic test_redirect_pop();
        mem_mode = 1'b1;
        do_reset(1'b1);
        for (int k = 0; k < 4; k++) step();
        #1;
        total++; if (bus.d_valid_o !== 1'b1) begin bad++; $display("FAIL rpop_pre_valid got=%b exp=1", bus.d_valid_o); end
        bus.redirect_i = 1'b1;
        bus.redirect_pc_i = 32'h01000202;
        #1;
        total++; if (bus.d_valid_o !== 1'b0) begin bad++; $display("FAIL rpop_valid got=%b exp=0", bus.d_valid_o); end
        step();
        bus.redirect_i = 1'b0;
        #1;
        total++; if (bus.count_o !== 3'd0) begin bad++; $display("FAIL rpop_count got=%0d exp=0", bus.count_o); end
        total++; if (bus.imem_addr_o !== 32'h01000200) begin bad++; $display("FAIL rpop_addr got=%h exp=01000200", bus.imem_addr_o); end
        step();
        step();
        #1;
        total++; if (bus.d_valid_o !== 1'b1 || bus.d_pc_o !== 32'h01000200) begin bad++; $display("FAIL rpop_target got=%b/%h exp=1/01000200", bus.d_valid_o, bus.d_pc_o); end
    endtask

    task automatic test_reset_mid();
        mem_mode = 1'b1;
        do_reset(1'b0);
        for (int k = 0; k < 6; k++) step();
        #1;
        total++; if (bus.full_o !== 1'b1) begin bad++; $display("FAIL rmid_full got=%b exp=1", bus.full_o); end
        rst = 1'b1;
        bus.redirect_i = 1'b1;
        bus.redirect_pc_i = 32'h02000000;
        #1;
        total++; if (bus.imem_req_o !== 1'b0) begin bad++; $display("FAIL rmid_req got=%b exp=0", bus.imem_req_o); end
        step();
        rst = 1'b0;
        bus.redirect_i = 1'b0;
        #1;
        total++; if (bus.count_o !== 3'd0) begin bad++; $display("FAIL rmid_count got=%0d exp=0", bus.count_o); end
        total++; if (bus.d_insn_o !== NOP) begin bad++; $display("FAIL rmid_insn got=%h exp=%h", bus.d_insn_o, NOP); end
        total++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== BASE) begin bad++; $display("FAIL rmid_addr got=%b/%h exp=1/%h", bus.imem_req_o, bus.imem_addr_o, BASE); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc;
        int pops;
        mem_mode = 1'b1;
        do_reset(1'b0);
        bus.redirect_i = 1'b1;
        bus.redirect_pc_i = 32'hFFFFFFFC;
        step();
        bus.redirect_i = 1'b0;
        #1;
        total++; if (bus.imem_addr_o !== 32'hFFFFFFFC) begin bad++; $display("FAIL wrap_addr0 got=%h exp=fffffffc", bus.imem_addr_o); end
        step();
        #1;
        total++; if (bus.imem_addr_o !== 32'h00000000) begin bad++; $display("FAIL wrap_addr1 got=%h exp=00000000", bus.imem_addr_o); end
        exp_pc = 32'hFFFFFFFC;
        pops = 0;
        for (int k = 0; k < 60; k++) begin
            bus.d_ready_i = 1'($urandom_range(0, 1));
            #1;
            total++; if (bus.count_o > 3'd4) begin bad++; $display("FAIL wrap_count k=%0d got=%0d exp<=4", k, bus.count_o); end
            if (bus.d_valid_o && bus.d_ready_i) begin
                total++; if (bus.d_pc_o !== exp_pc) begin bad++; $display("FAIL wrap_pc k=%0d got=%h exp=%h", k, bus.d_pc_o, exp_pc); end
                total++; if (bus.d_insn_o !== mem_word(exp_pc)) begin bad++; $display("FAIL wrap_insn k=%0d got=%h exp=%h", k, bus.d_insn_o, mem_word(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            step();
        end
        total++; if (pops < 13) begin bad++; $display("FAIL wrap_pops got=%0d exp>=13", pops); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_pop();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
